mem_lock_arbiter: RTL and testbench

//  Parametrised C-core front end for shared main memory and the global lock table. Replaces the fixed
//  two-core dmem hookup: round-robin arbitration of core load/store requests onto one synchronous

---
 rtl/mem_lock_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_lock_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lock_arbiter.sv
// Round-robin front end for a shared single-port data RAM,
// plus a small lock table giving cores mutual exclusion.
module mem_lock_arbiter #(
  parameter int C     = 2,
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int LAW   = 10,
  parameter int LOCKS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [C-1:0][AW-1:0]  main_mem_read_adr,
  input  logic [C-1:0][AW-1:0]  main_mem_write_adr,
  input  logic [C-1:0][DW-1:0]  main_mem_write_dat,
  input  logic [C-1:0]          main_mem_read,
  input  logic [C-1:0]          main_mem_write,
  output logic [DW-1:0]         main_mem_dat,
  output logic [C-1:0]          main_mem_ac,
  input  logic [C-1:0][LAW-1:0] lock_adr,
  input  logic [C-1:0]          lock_en,
  input  logic [C-1:0]          unlock_en,
  output logic [C-1:0]          lock_ac,
  output logic [AW-1:0]         ram_adr,
  output logic [DW-1:0]         ram_wdat,
  output logic                  ram_we,
  input  logic [DW-1:0]         ram_rdat,
  output logic                  lock_err
);

  localparam int GW = (C > 1) ? $clog2(C) : 1;
  localparam int LW = (LOCKS > 1) ? $clog2(LOCKS) : 1;

  // First set bit strictly after ptr, wrapping; MSB flags a hit.
  function automatic logic [GW:0] rr_pick(
    input logic [C-1:0]  vec,
    input logic [GW-1:0] ptr
  );
    logic [GW:0] r;
    int idx;
    r = '0;
    for (int k = C; k >= 1; k--) begin
      idx = (int'(ptr) + k) % C;
      if (vec[idx]) r = {1'b1, GW'(idx)};
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [GW-1:0] g;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] win;
  logic          win_found;
  logic          is_write;
  logic [C-1:0]  req;
  logic [DW-1:0] dat_q;

  assign req = main_mem_read | main_mem_write;
  assign {win_found, win} = rr_pick(req, last_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      g          <= '0;
      is_write   <= 1'b0;
      last_grant <= GW'(C - 1);
      dat_q      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && win_found) begin
        g        <= win;
        is_write <= main_mem_write[win];
      end
      if (state == RESP) begin
        last_grant <= g;
        dat_q      <= ram_rdat;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    ram_adr      = '0;
    ram_we       = 1'b0;
    ram_wdat     = '0;
    main_mem_ac  = '0;
    main_mem_dat = dat_q;
    unique case (state)
      IDLE: begin
        if (win_found) state_nx = ACCESS;
      end
      ACCESS: begin
        ram_adr  = is_write ? main_mem_write_adr[g]
                            : main_mem_read_adr[g];
        ram_we   = is_write;
        ram_wdat = main_mem_write_dat[g];
        state_nx = RESP;
      end
      RESP: begin
        main_mem_ac[g] = 1'b1;
        main_mem_dat   = ram_rdat;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [C-1:0]              mask;
  logic [C-1:0]              elig;
  logic [GW-1:0]             lptr;
  logic [GW-1:0]             lw;
  logic                      l_found;
  logic [LOCKS-1:0]          valid;
  logic [LOCKS-1:0][LAW-1:0] tadr;
  logic [LOCKS-1:0][GW-1:0]  towner;
  logic [LOCKS-1:0]          hit_own;
  logic [LOCKS-1:0]          hit_oth;
  logic [LW-1:0]             free_idx;
  logic [LAW-1:0]            a;
  logic                      lk;
  logic                      ul;
  logic                      own;
  logic                      oth;
  logic                      room;
  logic                      do_ac;
  logic                      do_err;
  logic                      do_alloc;
  logic                      do_free;

  // A just-acked core is masked while its request is still held.
  assign elig = (lock_en | unlock_en) & ~mask;
  assign {l_found, lw} = rr_pick(elig, lptr);

  always_comb begin
    a        = lock_adr[lw];
    hit_own  = '0;
    hit_oth  = '0;
    free_idx = '0;
    for (int e = LOCKS - 1; e >= 0; e--) begin
      if (valid[e] && tadr[e] == a) begin
        if (towner[e] == lw) hit_own[e] = 1'b1;
        else                 hit_oth[e] = 1'b1;
      end
      if (!valid[e]) free_idx = LW'(e);
    end
    lk       = l_found & ~unlock_en[lw];
    ul       = l_found & unlock_en[lw];
    own      = |hit_own;
    oth      = |hit_oth;
    room     = ~&valid;
    do_ac    = 1'b0;
    do_err   = 1'b0;
    do_alloc = 1'b0;
    do_free  = 1'b0;
    unique case (1'b1)
      ul & own: begin
        do_ac   = 1'b1;
        do_free = 1'b1;
      end
      ul & ~own: begin
        do_ac  = 1'b1;
        do_err = 1'b1;
      end
      lk & own: do_ac = 1'b1;
      lk & ~own & ~oth & room: begin
        do_ac    = 1'b1;
        do_alloc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= '0;
      tadr     <= '0;
      towner   <= '0;
      mask     <= '0;
      lptr     <= GW'(C - 1);
      lock_ac  <= '0;
      lock_err <= 1'b0;
    end else begin
      lock_ac  <= '0;
      mask     <= '0;
      lock_err <= do_err;
      if (l_found) lptr <= lw;
      if (do_ac) begin
        lock_ac[lw] <= 1'b1;
        mask[lw]    <= 1'b1;
      end
      if (do_free) valid <= valid & ~hit_own;
      if (do_alloc) begin
        valid[free_idx]  <= 1'b1;
        tadr[free_idx]   <= a;
        towner[free_idx] <= lw;
      end
    end
  end

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Bench for mem_lock_arbiter: lock vector table, directed
// memory/reset sequences, randomized memory traffic vs model.
module tb_mem_lock_arbiter;

  logic              clk;
  logic              reset;
  logic [3:0][15:0]  rd_adr;
  logic [3:0][15:0]  wr_adr;
  logic [3:0][15:0]  wr_dat;
  logic [3:0]        rd;
  logic [3:0]        wr;
  logic [15:0]       mdat;
  logic [3:0]        mac;
  logic [3:0][9:0]   ladr;
  logic [3:0]        len;
  logic [3:0]        ulen;
  logic [3:0]        lac;
  logic [15:0]       ram_adr;
  logic [15:0]       ram_wdat;
  logic [15:0]       ram_rdat;
  logic              ram_we;
  logic              lerr;

  logic [15:0] ram [0:65535];

  mem_lock_arbiter #(
    .C(4), .AW(16), .DW(16), .LAW(10), .LOCKS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .main_mem_read_adr(rd_adr),
    .main_mem_write_adr(wr_adr),
    .main_mem_write_dat(wr_dat),
    .main_mem_read(rd),
    .main_mem_write(wr),
    .main_mem_dat(mdat),
    .main_mem_ac(mac),
    .lock_adr(ladr),
    .lock_en(len),
    .unlock_en(ulen),
    .lock_ac(lac),
    .ram_adr(ram_adr),
    .ram_wdat(ram_wdat),
    .ram_we(ram_we),
    .ram_rdat(ram_rdat),
    .lock_err(lerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_adr] <= ram_wdat;
    ram_rdat <= ram[ram_adr];
  end

  int n_chk;
  int n_fail;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int rr_next(input logic [3:0] v,
                                 input int last);
    for (int k = 1; k <= 4; k++)
      if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic clr_inputs();
    rd = '0; wr = '0; len = '0; ulen = '0;
    rd_adr = '0; wr_adr = '0; wr_dat = '0; ladr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clr_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int         core;
    logic       lk;
    logic       ul;
    logic [9:0] adr;
    logic       ac;
    logic       err;
  } lvec_t;

  lvec_t lt [17];

  task automatic lock_vec(input lvec_t v, input int i);
    string nm;
    nm = $sformatf("lockvec%0d", i);
    @(negedge clk);
    len[v.core]  = v.lk;
    ulen[v.core] = v.ul;
    ladr[v.core] = v.adr;
    @(negedge clk);
    chk({nm, "_ac"}, lac, v.ac ? (32'd1 << v.core) : 32'd0);
    chk({nm, "_err"}, lerr, v.err);
    if (!v.ac) begin
      repeat (2) @(negedge clk);
      chk({nm, "_stall"}, lac, 0);
    end
    len[v.core]  = 1'b0;
    ulen[v.core] = 1'b0;
    @(negedge clk);
    chk({nm, "_pulse"}, {lac, lerr}, 0);
  endtask

  // random-phase state
  logic [3:0]  pend;
  logic [3:0]  pw;
  logic [3:0]  acked;
  int          pa [4];
  logic [15:0] pdat [4];
  logic [15:0] mdl [16];
  logic [3:0]  hist [4];
  int          last;
  int          k;
  int          e;
  int          g1;
  logic        started;
  logic        done;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 65536; i++)
      ram[i] <= 16'(i) ^ 16'h5A5A;
    ram[16'h0010] <= 16'hBEEF;
    for (int i = 0; i < 16; i++)
      mdl[i] = 16'(16'h40 + i) ^ 16'h5A5A;
    reset = 1'b1;
    clr_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs",
        {mac, lac, lerr, ram_we, ram_adr, ram_wdat, mdat},
        0);
    reset = 1'b0;

    // single-requester lock table vectors (LOCKS=2)
    lt[0]  = '{0, 1'b1, 1'b0, 10'h003, 1'b1, 1'b0};
    lt[1]  = '{1, 1'b1, 1'b0, 10'h003, 1'b0, 1'b0};
    lt[2]  = '{0, 1'b1, 1'b0, 10'h003, 1'b1, 1'b0};
    lt[3]  = '{1, 1'b1, 1'b0, 10'h004, 1'b1, 1'b0};
    lt[4]  = '{2, 1'b1, 1'b0, 10'h005, 1'b0, 1'b0};
    lt[5]  = '{3, 1'b0, 1'b1, 10'h007, 1'b1, 1'b1};
    lt[6]  = '{1, 1'b0, 1'b1, 10'h003, 1'b1, 1'b1};
    lt[7]  = '{0, 1'b0, 1'b1, 10'h003, 1'b1, 1'b0};
    lt[8]  = '{2, 1'b1, 1'b0, 10'h005, 1'b1, 1'b0};
    lt[9]  = '{2, 1'b1, 1'b0, 10'h003, 1'b0, 1'b0};
    lt[10] = '{1, 1'b0, 1'b1, 10'h004, 1'b1, 1'b0};
    lt[11] = '{3, 1'b1, 1'b0, 10'h003, 1'b1, 1'b0};
    lt[12] = '{3, 1'b1, 1'b1, 10'h003, 1'b1, 1'b0};
    lt[13] = '{0, 1'b1, 1'b0, 10'h003, 1'b1, 1'b0};
    lt[14] = '{1, 1'b1, 1'b0, 10'h006, 1'b0, 1'b0};
    lt[15] = '{2, 1'b0, 1'b1, 10'h005, 1'b1, 1'b0};
    lt[16] = '{1, 1'b1, 1'b0, 10'h3FF, 1'b1, 1'b0};
    for (int i = 0; i < 17; i++) lock_vec(lt[i], i);

    // contention: core1 waits on core0's lock
    do_reset();
    len[0] = 1'b1; ladr[0] = 10'h003;
    @(negedge clk);
    chk("cont_c0_ac", lac, 4'b0001);
    len[0] = 1'b0;
    len[1] = 1'b1; ladr[1] = 10'h003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cont_c1_wait", lac, 0);
    end
    ulen[0] = 1'b1;
    @(negedge clk);
    chk("cont_c0_unlock", {lac, lerr}, {4'b0001, 1'b0});
    ulen[0] = 1'b0;
    @(negedge clk);
    chk("cont_c1_ac", lac, 4'b0010);
    len[1] = 1'b0;

    // core0 read of 0x0010
    do_reset();
    rd[0] = 1'b1; rd_adr[0] = 16'h0010;
    @(negedge clk);
    chk("rd_access", {mac, ram_we, ram_adr}, {4'b0, 1'b0, 16'h0010});
    @(negedge clk);
    chk("rd_ac", {mac, ram_we, mdat}, {4'b0001, 1'b0, 16'hBEEF});
    rd[0] = 1'b0;
    @(negedge clk);
    chk("rd_hold", {mac, ram_we, mdat}, {4'b0, 1'b0, 16'hBEEF});

    // all four cores write together
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr[i] = 1'b1;
      wr_adr[i] = 16'(i);
      wr_dat[i] = 16'(16'h100 + i);
    end
    k = 0;
    for (int c = 1; c <= 20 && k < 4; c++) begin
      @(negedge clk);
      if (mac != 0) begin
        chk("wall_order", mac, 32'd1 << k);
        chk("wall_time", c, 2 + 3 * k);
        wr = wr & ~mac;
        k++;
      end
    end
    chk("wall_count", k, 4);
    for (int i = 0; i < 4; i++)
      chk("wall_ram", ram[i], 16'h100 + i);

    // fairness: core1 always requesting, core0 once
    do_reset();
    rd_adr[0] = 16'h0041; rd_adr[1] = 16'h0042;
    g1 = 0; started = 1'b0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mac[1]) begin
        rd[1] = 1'b0;
        if (started) g1++;
      end else begin
        rd[1] = 1'b1;
      end
      if (mac[0]) begin
        rd[0] = 1'b0;
        done = 1'b1;
        chk("fair_grants", g1 <= 1, 1);
      end
      if (c == 4) begin
        rd[0] = 1'b1;
        started = 1'b1;
      end
    end
    chk("fair_done", done, 1);

    // reset while in ACCESS
    do_reset();
    len[0] = 1'b1; ladr[0] = 10'h001;
    @(negedge clk);
    chk("rst_lock0", lac, 4'b0001);
    len[0] = 1'b0;
    rd[2] = 1'b1; rd_adr[2] = 16'h0020;
    @(negedge clk);
    chk("rst_in_access", ram_adr, 16'h0020);
    reset = 1'b1;
    rd[2] = 1'b0;
    @(negedge clk);
    chk("rst_outs",
        {mac, lac, lerr, ram_we, ram_adr, ram_wdat, mdat},
        0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_ac", {mac, ram_we}, 0);
    end
    len[1] = 1'b1; ladr[1] = 10'h001;
    @(negedge clk);
    chk("rst_regrant", lac, 4'b0010);
    len[1] = 1'b0;

    // randomized traffic against the behavioural model
    do_reset();
    pend = '0; pw = '0; last = 3;
    for (int i = 0; i < 4; i++) hist[i] = '0;
    for (int m = 0; m < 460; m++) begin
      @(negedge clk);
      acked = mac;
      if (mac != 0) begin
        chk("rnd_onehot", $onehot(mac), 1);
        k = 0;
        for (int j = 3; j >= 0; j--) if (mac[j]) k = j;
        e = rr_next(hist[(m + 2) % 4], last);
        chk("rnd_grant", k, e);
        last = k;
        if (pend[k]) begin
          if (pw[k]) mdl[pa[k]] = pdat[k];
          else chk("rnd_rdata", mdat, mdl[pa[k]]);
        end
        pend[k] = 1'b0;
        rd[k] = 1'b0;
        wr[k] = 1'b0;
      end
      if (m < 400) begin
        for (int j = 0; j < 4; j++) begin
          if (!pend[j] && !acked[j] && $urandom_range(0, 3) == 0) begin
            pend[j]   = 1'b1;
            pw[j]     = 1'($urandom_range(0, 1));
            pa[j]     = $urandom_range(0, 15);
            pdat[j]   = 16'($urandom);
            rd_adr[j] = 16'(16'h40 + pa[j]);
            wr_adr[j] = 16'(16'h40 + pa[j]);
            wr_dat[j] = pdat[j];
            rd[j]     = ~pw[j];
            wr[j]     = pw[j];
          end
        end
      end
      hist[m % 4] = rd | wr;
    end
    chk("rnd_drained", pend, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
